// File: rtl/ps2_scan_decoder_if.sv
// rtl/ps2_scan_decoder_if.sv - receiver handshake and key-event bus of the scan decoder
interface ps2_scan_decoder_if;
  logic       ready;
  logic [7:0] data;
  logic       nextdata_n;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_make;
  logic       evt_repeat;
  logic [7:0] evt_ascii;
  logic [7:0] key_count;
  logic       shift_on;
  logic       caps_on;

  // environment side: receiver FIFO feeding bytes, display logic consuming events
  modport master (
    output ready, data,
    input  nextdata_n, evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
    input  evt_ascii, key_count, shift_on, caps_on
  );

  // decoder side
  modport slave (
    input  ready, data,
    output nextdata_n, evt_valid, evt_code, evt_ext, evt_make, evt_repeat,
    output evt_ascii, key_count, shift_on, caps_on
  );
endinterface

// File: rtl/ps2_scan_decoder.sv
// rtl/ps2_scan_decoder.sv - PS/2 Set-2 scan-code decoder with held-key and modifier tracking
module ps2_scan_decoder (
  input  logic                 clk,
  input  logic                 rst,
  ps2_scan_decoder_if.slave    bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_POP = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       nextdata_n_q, nextdata_n_d;
  logic       evt_valid_q, evt_valid_d;
  logic [7:0] evt_code_q, evt_code_d;
  logic       evt_ext_q, evt_ext_d;
  logic       evt_make_q, evt_make_d;
  logic       evt_repeat_q, evt_repeat_d;
  logic [7:0] evt_ascii_q, evt_ascii_d;
  logic [7:0] key_count_q, key_count_d;
  logic       ext_f_q, ext_f_d;
  logic       brk_f_q, brk_f_d;
  logic       held_v_q, held_v_d;
  logic [7:0] held_code_q, held_code_d;
  logic       held_ext_q, held_ext_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  logic       caps_q, caps_d;

  logic       is_make;
  logic       held_match;

  // Set-2 code to ASCII; letters fold to uppercase when upper is set, extended codes never map
  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext, input logic upper);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    if (ext) begin
      a = 8'h00;
    end else if (upper && (a >= 8'h61) && (a <= 8'h7A)) begin
      a = a - 8'h20;
    end
    return a;
  endfunction

  // state, event and tracking registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= 8'h00;
      evt_ext_q    <= 1'b0;
      evt_make_q   <= 1'b0;
      evt_repeat_q <= 1'b0;
      evt_ascii_q  <= 8'h00;
      key_count_q  <= 8'h00;
      ext_f_q      <= 1'b0;
      brk_f_q      <= 1'b0;
      held_v_q     <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      caps_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
      evt_ext_q    <= evt_ext_d;
      evt_make_q   <= evt_make_d;
      evt_repeat_q <= evt_repeat_d;
      evt_ascii_q  <= evt_ascii_d;
      key_count_q  <= key_count_d;
      ext_f_q      <= ext_f_d;
      brk_f_q      <= brk_f_d;
      held_v_q     <= held_v_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      caps_q       <= caps_d;
    end
  end

  // fetch FSM and byte decode; the byte is decoded on the same edge that issues the pop
  always_comb begin
    state_d      = state_q;
    nextdata_n_d = 1'b1;
    evt_valid_d  = 1'b0;
    evt_code_d   = evt_code_q;
    evt_ext_d    = evt_ext_q;
    evt_make_d   = evt_make_q;
    evt_repeat_d = evt_repeat_q;
    evt_ascii_d  = evt_ascii_q;
    key_count_d  = key_count_q;
    ext_f_d      = ext_f_q;
    brk_f_d      = brk_f_q;
    held_v_d     = held_v_q;
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    caps_d       = caps_q;
    is_make      = ~brk_f_q;
    held_match   = held_v_q && (held_code_q == bus.data) && (held_ext_q == ext_f_q);

    case (state_q)
      ST_IDLE: begin
        if (bus.ready) begin
          nextdata_n_d = 1'b0;
          state_d      = ST_POP;
          if (bus.data == 8'hE0) begin
            ext_f_d = 1'b1;
          end else if (bus.data == 8'hF0) begin
            brk_f_d = 1'b1;
          end else begin
            evt_valid_d  = 1'b1;
            evt_code_d   = bus.data;
            evt_ext_d    = ext_f_q;
            evt_make_d   = is_make;
            evt_repeat_d = is_make && held_match;
            // case selection uses the modifier state from before this event
            evt_ascii_d  = to_ascii(bus.data, ext_f_q, (lshift_q | rshift_q) ^ caps_q);
            if (is_make && !held_match) begin
              key_count_d = key_count_q + 8'd1;
              held_v_d    = 1'b1;
              held_code_d = bus.data;
              held_ext_d  = ext_f_q;
            end else if (!is_make && held_match) begin
              held_v_d = 1'b0;
            end
            if (!ext_f_q) begin
              if (bus.data == 8'h12) lshift_d = is_make;
              if (bus.data == 8'h59) rshift_d = is_make;
              if ((bus.data == 8'h58) && is_make && !held_match) caps_d = ~caps_q;
            end
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
          end
        end
      end
      ST_POP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.nextdata_n = nextdata_n_q;
  assign bus.evt_valid  = evt_valid_q;
  assign bus.evt_code   = evt_code_q;
  assign bus.evt_ext    = evt_ext_q;
  assign bus.evt_make   = evt_make_q;
  assign bus.evt_repeat = evt_repeat_q;
  assign bus.evt_ascii  = evt_ascii_q;
  assign bus.key_count  = key_count_q;
  assign bus.shift_on   = lshift_q | rshift_q;
  assign bus.caps_on    = caps_q;

endmodule
